// File: rtl/rst_seq.sv
// rst_seq: multi-channel reset sequencer; holds all domains in reset, then releases them one by one
module rst_seq #(
  parameter int NUM_CH      = 4,
  parameter int RST_LENGTH  = 10,
  parameter int STAGE_GAP   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 8
) (
  input  logic              clk_100m00,
  input  logic              rst_n_100m00,
  input  logic              rst_ext,
  input  logic              locked,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] rst_out,
  output logic              rst_done,
  output logic [1:0]        rst_cause
);
  localparam int M1 = RST_LENGTH > STAGE_GAP ? RST_LENGTH : STAGE_GAP;
  localparam int MX = M1 > DEBOUNCE ? M1 : DEBOUNCE;
  localparam int CW = $clog2(MX + 1);
  localparam int IW = $clog2(NUM_CH + 1);
  typedef enum logic [1:0] {HOLD, STAGE, DONE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] ext_sh, lock_sh;
  logic [CW-1:0] db_cnt, hold_cnt, hold_n, gap_cnt, gap_n;
  logic [IW-1:0] idx, idx_n;
  logic [NUM_CH-1:0] rst_out_n;
  logic [1:0] cause_n;
  logic db_flag, ext_s, lock_sync, ext_db, trigger, done_n;
  assign ext_s     = ext_sh[SYNC_STAGES-1];
  assign lock_sync = lock_sh[SYNC_STAGES-1];
  // the debounced level drops on the very first low sample, so gate the flag combinationally
  assign ext_db    = db_flag & ext_s;
  assign trigger   = ext_db | ~lock_sync | sw_rst_req;
  always_ff @(posedge clk_100m00) begin
    if (!rst_n_100m00) begin
      ext_sh    <= '0;
      lock_sh   <= '0;
      db_cnt    <= '0;
      db_flag   <= 1'b0;
      state     <= HOLD;
      rst_out   <= '1;
      rst_done  <= 1'b0;
      rst_cause <= 2'd0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      idx       <= '0;
    end else begin
      ext_sh  <= {ext_sh[SYNC_STAGES-2:0], rst_ext};
      lock_sh <= {lock_sh[SYNC_STAGES-2:0], locked};
      if (!ext_s) begin
        db_cnt  <= '0;
        db_flag <= 1'b0;
      end else if (db_cnt == CW'(DEBOUNCE - 1)) db_flag <= 1'b1;
      else db_cnt <= db_cnt + 1'b1;
      state     <= state_n;
      rst_out   <= rst_out_n;
      rst_done  <= done_n;
      rst_cause <= cause_n;
      hold_cnt  <= hold_n;
      gap_cnt   <= gap_n;
      idx       <= idx_n;
    end
  end
  always_comb begin
    state_n   = state;
    rst_out_n = rst_out;
    done_n    = rst_done;
    cause_n   = rst_cause;
    hold_n    = hold_cnt;
    gap_n     = gap_cnt;
    idx_n     = idx;
    if (state == HOLD) begin
      if (trigger) hold_n = '0;
      else if (hold_cnt == CW'(RST_LENGTH - 1)) begin
        state_n   = NUM_CH == 1 ? DONE : STAGE;
        rst_out_n = ~NUM_CH'(1);
        done_n    = NUM_CH == 1;
        idx_n     = IW'(1);
        hold_n    = '0;
      end else hold_n = hold_cnt + 1'b1;
    end else if (trigger) begin
      state_n   = HOLD;
      rst_out_n = '1;
      done_n    = 1'b0;
      hold_n    = '0;
      gap_n     = '0;
      idx_n     = '0;
      cause_n   = ext_db ? 2'd1 : !lock_sync ? 2'd2 : 2'd3;
    end else if (state == STAGE) begin
      if (gap_cnt == CW'(STAGE_GAP - 1)) begin
        rst_out_n = rst_out & ~(NUM_CH'(1) << idx);
        idx_n     = idx + 1'b1;
        gap_n     = '0;
        if (idx == IW'(NUM_CH - 1)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end else gap_n = gap_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: table-driven and randomized checks of rst_seq against a timing-level reference model
module tb_rst_seq;
  localparam int SS = 2, D = 8, RL = 10;
  localparam int NCH[3] = '{4, 1, 4};
  localparam int GAP[3] = '{16, 16, 1};
  logic clk = 1'b0;
  logic rst_n = 1'b0, rst_ext = 1'b0, locked = 1'b1, sw = 1'b0;
  logic [3:0] o0, o2;
  logic [0:0] o1;
  logic d0, d1, d2;
  logic [1:0] c0, c1, c2;
  logic [6:0] act[3];
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  rst_seq u0 (.clk_100m00(clk), .rst_n_100m00(rst_n), .rst_ext(rst_ext), .locked(locked),
              .sw_rst_req(sw), .rst_out(o0), .rst_done(d0), .rst_cause(c0));
  rst_seq #(.NUM_CH(1)) u1 (.clk_100m00(clk), .rst_n_100m00(rst_n), .rst_ext(rst_ext), .locked(locked),
              .sw_rst_req(sw), .rst_out(o1), .rst_done(d1), .rst_cause(c1));
  rst_seq #(.STAGE_GAP(1)) u2 (.clk_100m00(clk), .rst_n_100m00(rst_n), .rst_ext(rst_ext), .locked(locked),
              .sw_rst_req(sw), .rst_out(o2), .rst_done(d2), .rst_cause(c2));
  assign act[0] = {o0, d0, c0};
  assign act[1] = {3'b000, o1, d1, c1};
  assign act[2] = {o2, d2, c2};
  // reference: sample delay lines, a run length for the debouncer, and per-config "held" / "time since release"
  bit ext_q[SS], lk_q[SS];
  int run;
  bit held[3];
  int cnt[3], rel[3];
  logic [1:0] cause[3];
  task automatic model_step();
    bit es, ls, et, tr;
    logic [1:0] cz;
    if (!rst_n) begin
      ext_q = '{default: 1'b0};
      lk_q  = '{default: 1'b0};
      run = 0;
      for (int c = 0; c < 3; c++) begin
        held[c] = 1'b1; cnt[c] = 0; rel[c] = 0; cause[c] = 2'd0;
      end
      return;
    end
    es = ext_q[SS-1];
    ls = lk_q[SS-1];
    et = es && run >= D;
    tr = et || !ls || sw;
    cz = et ? 2'd1 : !ls ? 2'd2 : 2'd3;
    run = es ? run + 1 : 0;
    for (int c = 0; c < 3; c++) begin
      if (held[c]) begin
        if (tr) cnt[c] = 0;
        else if (cnt[c] == RL - 1) begin held[c] = 1'b0; rel[c] = 0; end
        else cnt[c]++;
      end else if (tr) begin
        held[c] = 1'b1; cnt[c] = 0; cause[c] = cz;
      end else rel[c]++;
    end
    for (int i = SS - 1; i > 0; i--) begin
      ext_q[i] = ext_q[i-1];
      lk_q[i]  = lk_q[i-1];
    end
    ext_q[0] = rst_ext;
    lk_q[0]  = locked;
  endtask
  function automatic logic [6:0] mexp(int c);
    int n;
    logic [3:0] m, o;
    m = 4'((1 << NCH[c]) - 1);
    if (held[c]) return {m, 1'b0, cause[c]};
    n = 1 + rel[c] / GAP[c];
    if (n > NCH[c]) n = NCH[c];
    o = m & ~4'((1 << n) - 1);
    return {o, n == NCH[c], cause[c]};
  endfunction
  task automatic chk(string nm, logic [6:0] a, logic [6:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at %0t: got out/done/cause=%b want %b", nm, $time, a, e);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int c = 0; c < 3; c++) chk($sformatf("model_u%0d", c), act[c], mexp(c));
  endtask
  typedef struct packed {
    logic rn, ext, lk, sw;
    logic [7:0] n;
    logic [3:0] out;
    logic done;
    logic [1:0] cause;
  } vec_t;
  vec_t tbl[15];
  initial begin
    tbl = '{
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'd5,  4'hF, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'd11, 4'hF, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1,  4'hE, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'd15, 4'hE, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1,  4'hC, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'd16, 4'h8, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'd15, 4'h8, 1'b0, 2'd0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1,  4'h0, 1'b1, 2'd0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 8'd5,  4'h0, 1'b1, 2'd0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'd10, 4'h0, 1'b1, 2'd0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 8'd10, 4'h0, 1'b1, 2'd0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 8'd1,  4'hF, 1'b0, 2'd1},
      '{1'b1, 1'b1, 1'b1, 1'b0, 8'd9,  4'hF, 1'b0, 2'd1},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'd11, 4'hF, 1'b0, 2'd1},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1,  4'hE, 1'b0, 2'd1}};
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      rst_n = tbl[i].rn; rst_ext = tbl[i].ext; locked = tbl[i].lk; sw = tbl[i].sw;
      repeat (int'(tbl[i].n)) cyc();
      chk($sformatf("tbl%0d", i), act[0], {tbl[i].out, tbl[i].done, tbl[i].cause});
    end
    repeat (16) cyc();
    chk("sw_pre", act[0], {4'hC, 1'b0, 2'd1});
    sw = 1'b1; cyc(); sw = 1'b0;
    chk("sw_hit", act[0], {4'hF, 1'b0, 2'd3});
    repeat (9) cyc();
    chk("sw_hold", act[0], {4'hF, 1'b0, 2'd3});
    cyc();
    chk("sw_rel0", act[0], {4'hE, 1'b0, 2'd3});
    repeat (48) cyc();
    chk("sw_done", act[0], {4'h0, 1'b1, 2'd3});
    locked = 1'b0; cyc(); cyc();
    chk("lock_pre", act[0], {4'h0, 1'b1, 2'd3});
    sw = 1'b1; cyc(); sw = 1'b0;
    chk("lock_prio", act[0], {4'hF, 1'b0, 2'd2});
    repeat (5) cyc();
    locked = 1'b1;
    repeat (11) cyc();
    chk("lock_hold", act[0], {4'hF, 1'b0, 2'd2});
    cyc();
    chk("lock_rel0", act[0], {4'hE, 1'b0, 2'd2});
    repeat (16) cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("rstn_mid", act[0], {4'hF, 1'b0, 2'd0});
    repeat (11) cyc();
    chk("rstn_hold", act[0], {4'hF, 1'b0, 2'd0});
    cyc();
    chk("rstn_rel0", act[0], {4'hE, 1'b0, 2'd0});
    chk("one_ch_done", act[1], {4'h0, 1'b1, 2'd0});
    chk("gap1_a", act[2], {4'hE, 1'b0, 2'd0});
    cyc();
    chk("gap1_b", act[2], {4'hC, 1'b0, 2'd0});
    cyc();
    chk("gap1_c", act[2], {4'h8, 1'b0, 2'd0});
    cyc();
    chk("gap1_d", act[2], {4'h0, 1'b1, 2'd0});
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 399) != 0;
      if ($urandom_range(0, 11) == 0) rst_ext = ~rst_ext;
      if (locked ? $urandom_range(0, 59) == 0 : $urandom_range(0, 5) == 0) locked = ~locked;
      sw = $urandom_range(0, 79) == 0;
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
